// File: rtl/mem_access_ctrl.sv
// Sequences one load/store at a time into strobes for an external MAR/MDR/memory datapath.
// Latency: rsp_valid in the 4th cycle after the accept edge, plus MEM_LAT wait cycles.
// Backpressure: req_ready is high only in IDLE; a request must be held until it is accepted.
module mem_access_ctrl #(
  parameter int MEM_LAT = 0,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  input  logic [31:0]       mdr_q,
  output logic [31:0]       bus_out,
  output logic              mar_en,
  output logic              mdr_en,
  output logic              read_from_mem,
  output logic              mem_write
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_LD_RD   = 3'd3;
  localparam logic [2:0] S_LD_CAP  = 3'd4;
  localparam logic [2:0] S_ST_DATA = 3'd5;
  localparam logic [2:0] S_ST_WR   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  // Wait counter start value; a zero-latency build never enters WAIT.
  localparam logic [3:0] LAT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wait_cnt;
  logic [2:0]        access_state;

  // First access state after the address phase depends on the latched op.
  assign access_state = op_write ? S_ST_DATA : S_LD_RD;

  // Next-state decode for the access sequence.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (req_valid) next_state = S_ADDR;
      S_ADDR:    next_state = (MEM_LAT > 0) ? S_WAIT : access_state;
      S_WAIT:    if (wait_cnt == 4'd0) next_state = access_state;
      S_LD_RD:   next_state = S_LD_CAP;
      S_LD_CAP:  next_state = S_DONE;
      S_ST_DATA: next_state = S_ST_WR;
      S_ST_WR:   next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // State register plus request latch, wait counter and load-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= 4'd0;
      rsp_rdata <= 32'd0;
    end else begin
      state <= next_state;
      // Request fields are only sampled on the accept edge; busy-time changes are ignored.
      if (state == S_IDLE && req_valid) begin
        op_write <= req_write;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == S_ADDR) begin
        wait_cnt <= LAT_INIT;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // MDR was loaded from memory on the previous edge, so mdr_q is valid here.
      if (state == S_LD_CAP) begin
        rsp_rdata <= mdr_q;
      end
    end
  end

  // Strobes and bus value decode purely from state so reset clears them immediately.
  always_comb begin
    bus_out = 32'd0;
    case (state)
      S_ADDR:    bus_out = {{(32-ADDR_W){1'b0}}, addr_q};
      S_ST_DATA: bus_out = wdata_q;
      default:   bus_out = 32'd0;
    endcase
  end

  assign req_ready     = reset_n && (state == S_IDLE);
  assign mar_en        = (state == S_ADDR);
  assign mdr_en        = (state == S_LD_RD) || (state == S_ST_DATA);
  assign read_from_mem = (state == S_LD_RD);
  assign mem_write     = (state == S_ST_WR);
  assign rsp_valid     = (state == S_DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_LAT=0 and MEM_LAT=2) around a behavioural MAR/MDR/memory.
// Latency: checked against the expected accept-to-rsp_valid distance held in the scoreboard.
// Backpressure: requests are held on req_valid until the sampled accept, then dropped.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        rv0, rw0, rr0, rsv0, me0, de0, rf0, mw0;
  logic [8:0]  ra0;
  logic [31:0] rwd0, rsd0, mq0, bo0;
  logic        rv1, rw1, rr1, rsv1, me1, de1, rf1, mw1;
  logic [8:0]  ra1;
  logic [31:0] rwd1, rsd1, mq1, bo1;

  mem_access_ctrl #(.MEM_LAT(0), .ADDR_W(9)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv0), .req_write(rw0), .req_addr(ra0), .req_wdata(rwd0), .req_ready(rr0),
    .rsp_valid(rsv0), .rsp_rdata(rsd0), .mdr_q(mq0), .bus_out(bo0),
    .mar_en(me0), .mdr_en(de0), .read_from_mem(rf0), .mem_write(mw0)
  );

  mem_access_ctrl #(.MEM_LAT(2), .ADDR_W(9)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv1), .req_write(rw1), .req_addr(ra1), .req_wdata(rwd1), .req_ready(rr1),
    .rsp_valid(rsv1), .rsp_rdata(rsd1), .mdr_q(mq1), .bus_out(bo1),
    .mar_en(me1), .mdr_en(de1), .read_from_mem(rf1), .mem_write(mw1)
  );

  // Shared memory; only instance 0 may write it, instance 1 is used for loads.
  logic [31:0] mem [512];
  logic [8:0]  mar0, mar1;
  logic [31:0] mdr0, mdr1;
  logic        poke_en;
  logic [8:0]  poke_addr;
  logic [31:0] poke_data;

  // Behavioural MAR/MDR/memory datapath for both instances.
  always_ff @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mw0) mem[mar0] <= mdr0;
    if (me0) mar0 <= bo0[8:0];
    if (de0) mdr0 <= rf0 ? mem[mar0] : bo0;
    if (me1) mar1 <= bo1[8:0];
    if (de1) mdr1 <= rf1 ? mem[mar1] : bo1;
  end
  assign mq0 = mdr0;
  assign mq1 = mdr1;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc0 = 0, acc_cyc1 = 0;
  bit acc0 = 0, acc1 = 0, drop0 = 0, drop1 = 0, saw_mw0 = 0;
  int first_acc;

  logic        s_rdy0, s_rsv0, s_me0, s_de0, s_rf0, s_mw0;
  logic [31:0] s_rsd0, s_bo0;
  logic        s_rdy1, s_rsv1, s_me1, s_de1, s_rf1, s_mw1;
  logic [31:0] s_rsd1, s_bo1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic inv(input string tag, input logic me, input logic de, input logic rf,
                     input logic mw, input logic [31:0] bo);
    logic bad_oh;
    logic bus_region;
    bad_oh     = (me & de) | (me & mw) | (de & mw);
    bus_region = me | (de & ~rf);
    chk({tag, "_strobe_onehot"}, {31'd0, bad_oh}, 32'd0);
    chk({tag, "_rfm_without_mdr"}, {31'd0, rf & ~de}, 32'd0);
    chk({tag, "_bus_quiet"}, bus_region ? 32'd0 : bo, 32'd0);
  endtask

  // Per-cycle sample at the falling edge: snapshots, invariants, scoreboard, accept tracking.
  task automatic monitor();
    exp_t e;
    cyc++;
    s_rdy0 = rr0; s_rsv0 = rsv0; s_me0 = me0; s_de0 = de0; s_rf0 = rf0; s_mw0 = mw0;
    s_rsd0 = rsd0; s_bo0 = bo0;
    s_rdy1 = rr1; s_rsv1 = rsv1; s_me1 = me1; s_de1 = de1; s_rf1 = rf1; s_mw1 = mw1;
    s_rsd1 = rsd1; s_bo1 = bo1;
    inv("i0", me0, de0, rf0, mw0, bo0);
    inv("i1", me1, de1, rf1, mw1, bo1);
    chk("i1_no_mem_write", {31'd0, mw1}, 32'd0);
    if (mw0) saw_mw0 = 1;
    if (rsv0) begin
      if (sb0.size() == 0) chk("i0_unexpected_rsp", {31'd0, rsv0}, 32'd0);
      else begin
        e = sb0.pop_front();
        chk("i0_latency", 32'(cyc - acc_cyc0), 32'(e.lat));
        if (!e.wr) chk("i0_rdata", rsd0, e.rdata);
      end
    end
    if (rsv1) begin
      if (sb1.size() == 0) chk("i1_unexpected_rsp", {31'd0, rsv1}, 32'd0);
      else begin
        e = sb1.pop_front();
        chk("i1_latency", 32'(cyc - acc_cyc1), 32'(e.lat));
        if (!e.wr) chk("i1_rdata", rsd1, e.rdata);
      end
    end
    if (rv0 && rr0) begin acc0 = 1; acc_cyc0 = cyc; drop0 = 1; end
    if (rv1 && rr1) begin acc1 = 1; acc_cyc1 = cyc; drop1 = 1; end
  endtask

  // One clock: sample at negedge, then return just after the rising edge for driving.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (drop0) begin rv0 = 1'b0; drop0 = 0; end
    if (drop1) begin rv1 = 1'b0; drop1 = 0; end
  endtask

  task automatic poke(input logic [8:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  task automatic drive_req(input int inst, input logic wr, input logic [8:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    e.wr = wr; e.rdata = exp_rd; e.lat = (inst == 0) ? 4 : 6;
    if (inst == 0) begin
      rw0 = wr; ra0 = a; rwd0 = wd; rv0 = 1'b1; acc0 = 0; sb0.push_back(e);
    end else begin
      rw1 = wr; ra1 = a; rwd1 = wd; rv1 = 1'b1; acc1 = 0; sb1.push_back(e);
    end
  endtask

  task automatic wait_acc(input int inst, input string tag);
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      got = (inst == 0) ? acc0 : acc1;
    end
    chk({tag, "_accepted"}, {31'd0, got}, 32'd1);
    if (!got) begin rv0 = 1'b0; rv1 = 1'b0; end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset_n = 1'b0;
    rv0 = 0; rw0 = 0; ra0 = '0; rwd0 = '0;
    rv1 = 0; rw1 = 0; ra1 = '0; rwd1 = '0;
    poke_en = 0; poke_addr = '0; poke_data = '0;

    // Reset held with random request activity.
    for (int k = 0; k < 5; k++) begin
      rv0 = 1'($urandom); rw0 = 1'($urandom); ra0 = 9'($urandom); rwd0 = $urandom;
      rv1 = 1'($urandom); rw1 = 1'($urandom); ra1 = 9'($urandom); rwd1 = $urandom;
      step();
      chk("rst_strobes0", {28'd0, s_me0, s_de0, s_rf0, s_mw0}, 32'd0);
      chk("rst_rsp0", {31'd0, s_rsv0}, 32'd0);
      chk("rst_rdata0", s_rsd0, 32'd0);
      chk("rst_bus0", s_bo0, 32'd0);
      chk("rst_rdata1", s_rsd1, 32'd0);
    end
    rv0 = 0; rv1 = 0;
    reset_n = 1'b1;
    step();
    chk("ready_after_reset0", {31'd0, s_rdy0}, 32'd1);
    chk("ready_after_reset1", {31'd0, s_rdy1}, 32'd1);

    // Basic load.
    poke(9'h054, 32'h97);
    drive_req(0, 1'b0, 9'h054, 32'h0, 32'h0000_0097);
    wait_acc(0, "ld54");
    step();
    chk("ld54_c1_mar", {31'd0, s_me0}, 32'd1);
    chk("ld54_c1_bus", s_bo0, 32'h0000_0054);
    step();
    chk("ld54_c2_mdr_rfm", {30'd0, s_de0, s_rf0}, 32'd3);
    step();
    chk("ld54_c3_idle_strobes", {29'd0, s_me0, s_de0, s_mw0}, 32'd0);
    step();
    chk("ld54_c4_rsp", {31'd0, s_rsv0}, 32'd1);
    step();
    chk("ld54_rsp_pulse", {31'd0, s_rsv0}, 32'd0);
    chk("ld54_ready_again", {31'd0, s_rdy0}, 32'd1);
    chk("ld54_rdata_held", s_rsd0, 32'h0000_0097);

    // Store then read back.
    poke(9'h034, 32'h25);
    drive_req(0, 1'b1, 9'h034, 32'hB6, 32'h0);
    wait_acc(0, "st34");
    step();
    chk("st34_c1_mar", {31'd0, s_me0}, 32'd1);
    step();
    chk("st34_c2_bus", s_bo0, 32'h0000_00B6);
    chk("st34_c2_mdr_bus", {30'd0, s_de0, s_rf0}, 32'd2);
    step();
    chk("st34_c3_write", {31'd0, s_mw0}, 32'd1);
    chk("st34_c3_bus", s_bo0, 32'd0);
    step();
    chk("st34_c4_rsp", {31'd0, s_rsv0}, 32'd1);
    chk("st34_rdata_kept", s_rsd0, 32'h0000_0097);
    step();
    chk("st34_mem", mem[9'h034], 32'h0000_00B6);
    drive_req(0, 1'b0, 9'h034, 32'h0, 32'h0000_00B6);
    wait_acc(0, "ld34");
    steps(5);

    // Request raised while busy; accepted only in the IDLE cycle after DONE.
    poke(9'h010, 32'h1234_5678);
    drive_req(0, 1'b0, 9'h010, 32'h0, 32'h1234_5678);
    wait_acc(0, "ld10");
    first_acc = acc_cyc0;
    drive_req(0, 1'b1, 9'h020, 32'hCAFE_0077, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("busy_ready_low", {31'd0, s_rdy0}, 32'd0);
    end
    wait_acc(0, "st20");
    chk("accept_spacing", 32'(acc_cyc0 - first_acc), 32'd5);
    steps(4);
    chk("st20_rdata_unchanged", s_rsd0, 32'h1234_5678);
    chk("st20_mem", mem[9'h020], 32'hCAFE_0077);
    step();

    // Reset during ST_DATA abandons the store.
    poke(9'h034, 32'h25);
    saw_mw0 = 0;
    drive_req(0, 1'b1, 9'h034, 32'hB6, 32'h0);
    wait_acc(0, "st34r");
    step();
    chk("st34r_c1_mar", {31'd0, s_me0}, 32'd1);
    reset_n = 1'b0;
    sb0.delete();
    step();
    chk("st34r_rst_strobes", {28'd0, s_me0, s_de0, s_rf0, s_mw0}, 32'd0);
    reset_n = 1'b1;
    steps(6);
    chk("st34r_no_mem_write", {31'd0, saw_mw0}, 32'd0);
    chk("st34r_mem_kept", mem[9'h034], 32'h0000_0025);
    drive_req(0, 1'b0, 9'h034, 32'h0, 32'h0000_0025);
    wait_acc(0, "ld34r");
    steps(5);
    chk("ld34r_done", 32'(sb0.size()), 32'd0);

    // MEM_LAT=2 instance, top address.
    poke(9'h1FF, 32'hDEAD_BEEF);
    drive_req(1, 1'b0, 9'h1FF, 32'h0, 32'hDEAD_BEEF);
    wait_acc(1, "ld1ff");
    step();
    chk("ld1ff_c1_mar", {31'd0, s_me1}, 32'd1);
    chk("ld1ff_c1_bus", s_bo1, 32'h0000_01FF);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("ld1ff_wait_strobes", {28'd0, s_me1, s_de1, s_rf1, s_mw1}, 32'd0);
    end
    step();
    chk("ld1ff_c4_mdr_rfm", {30'd0, s_de1, s_rf1}, 32'd3);
    step();
    step();
    chk("ld1ff_c6_rsp", {31'd0, s_rsv1}, 32'd1);
    step();
    chk("ld1ff_rdata", s_rsd1, 32'hDEAD_BEEF);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
